mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Two-requester arbiter that shares the single 16-bit memory port between the CPU control sequencer (port 0) and a debug/DMA loader (port 1). Each transaction is one word read or write. A 3-state FSM owns memAddr/memRe/memWe for a fixed WAIT_CYCLES access window, then returns read data with a one-cycle ack. Grant order is round-robin. Sits between control and the memory model.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
WAIT_CYCLES, 2, memory access cycles per transaction; legal 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req0  in  1  port 0 request
we0  in  1  port 0 write (1) / read (0)
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
gnt0  out  1  port 0 request captured, 1-cycle pulse
ack0  out  1  port 0 transaction complete, 1-cycle pulse
rdata0  out  DATA_W  port 0 read data
req1, we1, addr1, wdata1, gnt1, ack1, rdata1: same as port 0, for port 1
memAddr  out  ADDR_W  memory address
memRe  out  1  memory read enable
memWe  out  1  memory write enable
memWdata  out  DATA_W  memory write data
memRdata  in  DATA_W  memory read data
busy  out  1  transaction in flight

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-low. All outputs are registered.
- Reset values: state=IDLE; gnt*, ack*, memRe, memWe, busy = 0; memAddr, memWdata, rdata0, rdata1 = 0; waitCnt=0; lastGrant=1, so port 0 wins the first tie.
- IDLE:
  - If no request is sampled, stay in IDLE.
  - With exactly one req high, pick that port. With both high, pick the port that is not lastGrant.
  - On that edge: latch addr/we/wdata/id of the chosen port; set lastGrant=id; drive gnt[id]=1 for the next cycle only; load waitCnt=WAIT_CYCLES-1; go to ACCESS.
- ACCESS:
  - memAddr and memWdata hold the latched values; busy=1.
  - memRe = !we and memWe = we, held for all WAIT_CYCLES cycles.
  - waitCnt decrements each cycle. At the edge where waitCnt==0, move to RESP.
  - On that same edge, for a read, capture memRdata into rdata[id].
- RESP:
  - memRe=memWe=0; ack[id]=1 for this one cycle; busy=1.
  - Next state is always IDLE.
- Latency: a req sampled at edge k gives gnt high in cycle k+1 and ack high in cycle k+1+WAIT_CYCLES. Minimum spacing between transactions is WAIT_CYCLES+2 cycles.
- Request fields are captured at grant. A requester may drop req or change its fields after gnt.
- A req still high in the IDLE cycle after RESP starts a new transaction. The requester drops req at or before ack unless it wants another access.
- rdataN holds its value until the next read ack on that port. Writes and the other port's transactions leave it unchanged.
- Requests arriving in ACCESS or RESP are ignored until IDLE. There is no queue.
- Reset asserted mid-transaction: the FSM goes to IDLE and memRe/memWe clear immediately, without waiting for clk. No ack is issued, and the aborted transaction is lost. lastGrant returns to 1.
- Only one of gnt0/gnt1 and one of ack0/ack1 is ever high. memRe and memWe are never high together.

Test Plan:
1. WAIT_CYCLES=2. req0=1, we0=0, addr0=0x0010; memory returns 0xBEEF. Required: gnt0 high in the cycle after req is sampled; memRe high for 2 cycles with memAddr=0x0010; ack0 in the next cycle with rdata0=0xBEEF; busy high for 3 cycles.
2. req0 and req1 held high continuously, both reads. Required: grants alternate 0,1,0,1 with spacing of WAIT_CYCLES+2, and no two acks overlap.
3. req1=1, we1=1, addr1=0x0200, wdata1=0x1234. Required: memWe high for WAIT_CYCLES cycles with memAddr=0x0200 and memWdata=0x1234; memRe stays 0; ack1 pulses; rdata1 unchanged.
4. After reading 0xBEEF on port 0, port 1 reads 0x5555. Required: rdata0 still 0xBEEF and rdata1=0x5555.
5. Drive rst low in the 2nd ACCESS cycle of a port-0 read. Required: memRe drops before the next clk edge; no ack0; after release, a tie between the ports is granted to port 0.
6. Port 0 changes addr0 to 0x0099 one cycle after gnt0. Required: memAddr stays at the originally captured 0x0010.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between two single-word requesters.
// Grant one cycle after req is sampled, ack WAIT_CYCLES later; requests are only sampled in IDLE.
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRe,
  output logic              memWe,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            state;
  logic [3:0]        waitCnt;
  logic              lastGrant;
  logic              curId;
  logic              curWe;

  logic              pickValid;
  logic              pickId;
  logic              pickWe;
  logic [ADDR_W-1:0] pickAddr;
  logic [DATA_W-1:0] pickWdata;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    pickValid = req0 | req1;
    pickId    = 1'b0;
    if (req0 && req1) pickId = ~lastGrant;
    else if (req1)    pickId = 1'b1;
    pickWe    = pickId ? we1    : we0;
    pickAddr  = pickId ? addr1  : addr0;
    pickWdata = pickId ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      waitCnt   <= '0;
      lastGrant <= 1'b1;
      curId     <= 1'b0;
      curWe     <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      memAddr   <= '0;
      memWdata  <= '0;
      memRe     <= 1'b0;
      memWe     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (pickValid) begin
            curId     <= pickId;
            curWe     <= pickWe;
            lastGrant <= pickId;
            memAddr   <= pickAddr;
            memWdata  <= pickWdata;
            gnt0      <= ~pickId;
            gnt1      <= pickId;
            waitCnt   <= WAIT_LOAD;
            memRe     <= ~pickWe;
            memWe     <= pickWe;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (waitCnt == 4'd0) begin
            memRe <= 1'b0;
            memWe <= 1'b0;
            ack0  <= ~curId;
            ack1  <= curId;
            if (!curWe) begin
              if (curId) rdata1 <= memRdata;
              else       rdata0 <= memRdata;
            end
            state <= RESP;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          memRe <= 1'b0;
          memWe <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
